uart_image_receiver: RTL and testbench

//  Receiving end of the camera board's image UART link. Deserialises 8N1 bytes on rx_serial,

---
 rtl/uart_image_receiver.sv | 186 ++++++++++++++++++
 tb/tb_uart_image_receiver.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_image_receiver.sv
// Image UART link receiver: 8N1 deserialiser, sync-byte hunt, 15-bit pixel assembly into
// RAM writes, and XOR-checksum frame validation with timeout/framing-error abort.
module uart_image_receiver #(
  parameter int          CLKS_PER_BIT = 1085,
  parameter int          NUM_PIXELS   = 3072,
  parameter int          ADDR_W       = 13,
  parameter logic [7:0]  SYNC_BYTE    = 8'hAA,
  parameter int          TIMEOUT_BITS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_serial,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [14:0]       wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err
);

  localparam int CNT_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TO_W     = (TO_LIMIT > 2) ? $clog2(TO_LIMIT) : 1;
  localparam int PIX_W    = (NUM_PIXELS > 2) ? $clog2(NUM_PIXELS) : 1;

  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [TO_W-1:0]  TO_M1    = TO_W'(TO_LIMIT - 1);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NUM_PIXELS - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [1:0] ST_HUNT = 2'd0;
  localparam logic [1:0] ST_HI   = 2'd1;
  localparam logic [1:0] ST_LO   = 2'd2;
  localparam logic [1:0] ST_CHK  = 2'd3;

  logic             rx_p0, rx_p1;
  logic [1:0]       rx_state;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic [7:0]       rx_byte;
  logic             byte_vld, frm_err, start_seen;

  logic [1:0]       state;
  logic [TO_W-1:0]  to_cnt;
  logic [PIX_W-1:0] pix;
  logic [6:0]       hi_p0;
  logic [7:0]       csum;
  logic             timeout;

  // Stage 0/1: line synchroniser and bit-timing deserialiser
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_p0      <= 1'b1;
      rx_p1      <= 1'b1;
      rx_state   <= RX_IDLE;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      rx_byte    <= '0;
      byte_vld   <= 1'b0;
      frm_err    <= 1'b0;
      start_seen <= 1'b0;
    end else begin
      rx_p0      <= rx_serial;
      rx_p1      <= rx_p0;
      byte_vld   <= 1'b0;
      frm_err    <= 1'b0;
      start_seen <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (!rx_p1) begin
            rx_state   <= RX_START;
            bit_cnt    <= '0;
            start_seen <= 1'b1;
          end
        end
        RX_START: begin
          if (bit_cnt == HALF_M1) begin
            bit_cnt  <= '0;
            bit_idx  <= '0;
            rx_state <= rx_p1 ? RX_IDLE : RX_DATA;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (bit_cnt == FULL_M1) begin
            bit_cnt <= '0;
            shreg   <= {rx_p1, shreg[7:1]};
            if (bit_idx == 3'd7) rx_state <= RX_STOP;
            else                 bit_idx  <= bit_idx + 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: begin
          if (bit_cnt == FULL_M1) begin
            bit_cnt  <= '0;
            rx_state <= RX_IDLE;
            if (rx_p1) begin
              byte_vld <= 1'b1;
              rx_byte  <= shreg;
            end else begin
              frm_err  <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Idle-line watchdog only matters once a frame has started
  assign timeout = (state != ST_HUNT) && (to_cnt == TO_M1) && !start_seen;

  // Stage 2: frame FSM, pixel writes and checksum verdict
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_HUNT;
      to_cnt     <= '0;
      pix        <= '0;
      hi_p0      <= '0;
      csum       <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      if (state == ST_HUNT || start_seen) to_cnt <= '0;
      else                                to_cnt <= to_cnt + 1'b1;

      if (state != ST_HUNT && (frm_err || timeout)) begin
        frame_err <= 1'b1;
        busy      <= 1'b0;
        state     <= ST_HUNT;
      end else if (byte_vld) begin
        case (state)
          ST_HUNT: begin
            if (rx_byte == SYNC_BYTE) begin
              state <= ST_HI;
              busy  <= 1'b1;
              csum  <= '0;
              pix   <= '0;
            end
          end
          ST_HI: begin
            hi_p0 <= rx_byte[6:0];
            csum  <= csum ^ rx_byte;
            state <= ST_LO;
          end
          ST_LO: begin
            wr_en   <= 1'b1;
            wr_addr <= ADDR_W'(pix);
            wr_data <= {hi_p0, rx_byte};
            csum    <= csum ^ rx_byte;
            if (pix == PIX_LAST) begin
              state <= ST_CHK;
            end else begin
              pix   <= pix + 1'b1;
              state <= ST_HI;
            end
          end
          default: begin
            if (rx_byte == csum) frame_done <= 1'b1;
            else                 frame_err  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_HUNT;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_image_receiver.sv
// Directed bench for uart_image_receiver with an 8-clock bit time and 4-pixel frames.
module tb_uart_image_receiver;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_serial;
  logic        wr_en;
  logic [12:0] wr_addr;
  logic [14:0] wr_data;
  logic        busy;
  logic        frame_done;
  logic        frame_err;

  int n_cmp  = 0;
  int n_fail = 0;

  int          wr_cnt, done_cnt, err_cnt, both_cnt;
  logic [12:0] log_addr [16];
  logic [14:0] log_data [16];

  uart_image_receiver #(
    .CLKS_PER_BIT(8),
    .NUM_PIXELS  (4),
    .ADDR_W      (13),
    .SYNC_BYTE   (8'hAA),
    .TIMEOUT_BITS(32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_serial (rx_serial),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .frame_done(frame_done),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en) begin
      if (wr_cnt < 16) begin
        log_addr[wr_cnt] = wr_addr;
        log_data[wr_cnt] = wr_data;
      end
      wr_cnt = wr_cnt + 1;
    end
    if (frame_done) done_cnt = done_cnt + 1;
    if (frame_err)  err_cnt  = err_cnt + 1;
    if (frame_done && frame_err) both_cnt = both_cnt + 1;
  end

  task automatic clear_log();
    wr_cnt = 0; done_cnt = 0; err_cnt = 0; both_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    rx_serial = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_serial = b[i];
      repeat (8) @(negedge clk);
    end
    rx_serial = stop_bit;
    repeat (8) @(negedge clk);
    rx_serial = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] cs);
    send_byte(8'hAA, 1'b1);
    for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b1);
    send_byte(cs, 1'b1);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_writes(input string name);
    logic [14:0] exp_d [4];
    exp_d[0] = 15'h0102; exp_d[1] = 15'h0304; exp_d[2] = 15'h0506; exp_d[3] = 15'h0708;
    n_cmp++;
    if (wr_cnt !== 4) begin
      n_fail++;
      $display("FAIL %s_count: got %0d writes expected 4", name, wr_cnt);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (log_addr[i] !== 13'(i) || log_data[i] !== exp_d[i]) begin
          n_fail++;
          $display("FAIL %s_wr%0d: got (%0d,0x%h) expected (%0d,0x%h)", name, i,
                   log_addr[i], log_data[i], i, exp_d[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rx_serial = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++;
    if ({wr_en, wr_addr, wr_data, busy, frame_done, frame_err} !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected all zero",
               {wr_en, wr_addr, wr_data, busy, frame_done, frame_err});
    end
    rst = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_good_frame();
    clear_log();
    send_byte(8'hAA, 1'b1);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL good_busy_after_sync: got %b expected 1", busy);
    end
    for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b1);
    send_byte(8'h08, 1'b1);
    repeat (4) @(negedge clk);
    check_writes("good");
    check_int("good_done", done_cnt, 1);
    check_int("good_err", err_cnt, 0);
    check_int("good_busy_end", int'(busy), 0);
    n_cmp++;
    if (wr_addr !== 13'd3 || wr_data !== 15'h0708) begin
      n_fail++;
      $display("FAIL good_hold: got (%0d,0x%h) expected (3,0x0708)", wr_addr, wr_data);
    end
  endtask

  task automatic test_bad_checksum();
    clear_log();
    send_frame(8'h09);
    check_writes("badcs");
    check_int("badcs_done", done_cnt, 0);
    check_int("badcs_err", err_cnt, 1);
    check_int("badcs_busy", int'(busy), 0);
  endtask

  task automatic test_hunt();
    clear_log();
    send_byte(8'h55, 1'b1);
    send_byte(8'h13, 1'b1);
    check_int("hunt_no_write", wr_cnt, 0);
    check_int("hunt_busy", int'(busy), 0);
    send_frame(8'h08);
    check_writes("hunt");
    check_int("hunt_done", done_cnt, 1);
    check_int("hunt_err", err_cnt, 0);
  endtask

  task automatic test_glitch();
    clear_log();
    @(negedge clk);
    rx_serial = 1'b0;
    repeat (3) @(negedge clk);
    rx_serial = 1'b1;
    repeat (100) @(negedge clk);
    check_int("glitch_activity", wr_cnt + done_cnt + err_cnt, 0);
    check_int("glitch_busy", int'(busy), 0);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    check_int("glitch_still_hunt", wr_cnt + int'(busy), 0);
  endtask

  task automatic test_timeout();
    int waited;
    bit seen;
    clear_log();
    send_byte(8'hAA, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    waited = 0;
    seen = 0;
    while (!seen && waited < 300) begin
      @(negedge clk);
      waited++;
      if (frame_err) seen = 1;
    end
    n_cmp++;
    if (!seen || waited < 150 || waited > 200) begin
      n_fail++;
      $display("FAIL timeout_when: got err=%0d after %0d clks expected 1 within 150..200", seen, waited);
    end
    repeat (20) @(negedge clk);
    check_int("timeout_err_count", err_cnt, 1);
    check_int("timeout_done", done_cnt, 0);
    check_int("timeout_writes", wr_cnt, 1);
    n_cmp++;
    if (log_addr[0] !== 13'd0 || log_data[0] !== 15'h0102) begin
      n_fail++;
      $display("FAIL timeout_wr0: got (%0d,0x%h) expected (0,0x0102)", log_addr[0], log_data[0]);
    end
    check_int("timeout_busy", int'(busy), 0);
    clear_log();
    send_frame(8'h08);
    check_int("timeout_recover_done", done_cnt, 1);
    check_int("timeout_recover_err", err_cnt, 0);
  endtask

  task automatic test_framing_and_reset();
    clear_log();
    send_byte(8'hAA, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b0);
    repeat (20) @(negedge clk);
    check_int("framing_err", err_cnt, 1);
    check_int("framing_done", done_cnt, 0);
    check_int("framing_writes", wr_cnt, 1);
    check_int("framing_busy", int'(busy), 0);

    clear_log();
    send_byte(8'hAA, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({wr_en, wr_addr, wr_data, busy, frame_done, frame_err} !== 32'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got %b expected all zero",
               {wr_en, wr_addr, wr_data, busy, frame_done, frame_err});
    end
    rst = 1'b1;
    repeat (300) @(negedge clk);
    check_int("midreset_no_err", err_cnt, 0);
    clear_log();
    send_frame(8'h08);
    check_writes("after_reset");
    check_int("after_reset_done", done_cnt, 1);
    check_int("after_reset_err", err_cnt, 0);
  endtask

  initial begin
    clear_log();
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_hunt();
    test_glitch();
    test_timeout();
    test_framing_and_reset();
    check_int("never_both", both_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
